vga_fb_scanout: RTL

- Read side of the 160x120, 3-bit-colour framebuffer that the sprite/xy writer path fills.
- Generates 640x480@60 VGA timing from CLOCK_50 and fetches one framebuffer word per pixel through a 1-cycle-latency read port.
- Each framebuffer pixel is replicated into a 4x4 screen block.
- Drives the DE2 VGA DAC pins. Pulses vblank_start so writers can update the framebuffer safely.

---
 rtl/vga_fb_scanout_pkg.sv | 37 +++
 rtl/vga_fb_scanout_if.sv | 13 +
 rtl/vga_fb_scanout_timing.sv | 85 ++++++++
 rtl/vga_fb_scanout.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vga_fb_scanout_pkg.sv
// Shared constants and types for the 640x480 VGA framebuffer scanout.
package vga_fb_pkg;

  // Default 640x480@60 timing, in pixels and lines.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Framebuffer geometry: each word covers a 4x4 block of screen pixels.
  localparam int VGA_SCALE_SHIFT = 2;
  localparam int VGA_FB_W        = VGA_H_ACTIVE >> VGA_SCALE_SHIFT;
  localparam int VGA_FB_H        = VGA_V_ACTIVE >> VGA_SCALE_SHIFT;
  localparam int VGA_ADDR_W      = 15;

  // Width of the hcount/vcount registers (covers totals up to 1023).
  localparam int CNT_W = 10;

  // Bit positions inside a framebuffer word.
  localparam int CLR_R = 2;
  localparam int CLR_G = 1;
  localparam int CLR_B = 0;

  typedef logic [2:0] colour_t;

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port: address/strobe out, data back one clock later.
interface vga_fb_scanout_if
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W
);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  colour_t           fb_rdata;

  modport master (output fb_addr, output fb_rd_en, input fb_rdata);
  modport slave  (input fb_addr, input fb_rd_en, output fb_rdata);
endinterface

// File: rtl/vga_fb_scanout_timing.sv
// Pixel-clock divider, raster counters, raw sync/active and vblank strobe.
module vga_timing_gen
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SCALE_SHIFT = VGA_SCALE_SHIFT
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  output logic                         o_pix_clk,
  output logic                         o_tick,
  output logic [CNT_W-SCALE_SHIFT-1:0] o_xq,
  output logic                         o_row_adv,
  output logic                         o_frame_wrap,
  output logic                         o_active,
  output logic                         o_hs_n,
  output logic                         o_vs_n,
  output logic                         o_vblank_start
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_PRE  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             r_tog;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_vblank;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_hcount == H_LAST);
  assign w_frame_end = w_line_end && (r_vcount == V_LAST);

  // Divide CLOCK_50 by two; the high half of VGA_CLK is the tick cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_tog <= 1'b0;
    else         r_tog <= ~r_tog;
  end

  // Raster counters step once per pixel tick.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_tog) begin
      if (w_line_end) begin
        r_hcount <= '0;
        r_vcount <= w_frame_end ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  // One-cycle strobe as the last visible line rolls into blanking.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_vblank <= 1'b0;
    else         r_vblank <= r_tog && w_line_end && (r_vcount == V_PRE);
  end

  assign o_pix_clk      = r_tog;
  assign o_tick         = r_tog;
  assign o_xq           = r_hcount[CNT_W-1:SCALE_SHIFT];
  // Next framebuffer row begins after the last line of each replicated block.
  assign o_row_adv      = r_tog && w_line_end && (&r_vcount[SCALE_SHIFT-1:0]) && !w_frame_end;
  assign o_frame_wrap   = r_tog && w_frame_end;
  assign o_active       = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign o_hs_n         = !((r_hcount >= H_SS) && (r_hcount < H_SE));
  assign o_vs_n         = !((r_vcount >= V_SS) && (r_vcount < V_SE));
  assign o_vblank_start = r_vblank;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: address generation, 2-tick fetch pipeline, DAC drive.
module vga_fb_scanout
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int FB_W        = H_ACTIVE >> SCALE_SHIFT,
  parameter int ADDR_W      = VGA_ADDR_W
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  vga_fb_scanout_if.master        fb,
  output logic                    vblank_start,
  output logic                    VGA_CLK,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK,
  output logic                    VGA_SYNC,
  output logic [9:0]              VGA_R,
  output logic [9:0]              VGA_G,
  output logic [9:0]              VGA_B
);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  logic                         w_tick;
  logic                         w_pix_clk;
  logic [CNT_W-SCALE_SHIFT-1:0] w_xq;
  logic                         w_row_adv;
  logic                         w_frame_wrap;
  logic                         w_active;
  logic                         w_hs_n;
  logic                         w_vs_n;
  logic                         w_vblank;
  colour_t                      w_rdata;

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_fb_addr;
  logic              r_rd_en;
  logic              r_hs0;
  logic              r_vs0;
  logic              r_hs;
  logic              r_vs;
  logic              r_blank;
  logic [9:0]        r_r;
  logic [9:0]        r_g;
  logic [9:0]        r_b;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_timing (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .o_pix_clk     (w_pix_clk),
    .o_tick        (w_tick),
    .o_xq          (w_xq),
    .o_row_adv     (w_row_adv),
    .o_frame_wrap  (w_frame_wrap),
    .o_active      (w_active),
    .o_hs_n        (w_hs_n),
    .o_vs_n        (w_vs_n),
    .o_vblank_start(w_vblank)
  );

  assign w_rdata = fb.fb_rdata;

  // Row base tracks yq*FB_W incrementally so no multiplier is needed.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)           r_row_base <= '0;
    else if (w_frame_wrap) r_row_base <= '0;
    else if (w_row_adv)    r_row_base <= r_row_base + FB_W_A;
  end

  // Stage 0: issue the fetch; address holds its last value while blanked.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_fb_addr <= '0;
      r_rd_en   <= 1'b0;
      r_hs0     <= 1'b1;
      r_vs0     <= 1'b1;
    end else if (w_tick) begin
      r_rd_en <= w_active;
      r_hs0   <= w_hs_n;
      r_vs0   <= w_vs_n;
      if (w_active) r_fb_addr <= r_row_base + ADDR_W'(w_xq);
    end
  end

  // Pin stage: capture read data and align it with the delayed sync/blank.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else if (w_tick) begin
      r_hs    <= r_hs0;
      r_vs    <= r_vs0;
      r_blank <= r_rd_en;
      r_r     <= r_rd_en ? {10{w_rdata[CLR_R]}} : 10'd0;
      r_g     <= r_rd_en ? {10{w_rdata[CLR_G]}} : 10'd0;
      r_b     <= r_rd_en ? {10{w_rdata[CLR_B]}} : 10'd0;
    end
  end

  assign fb.fb_addr   = r_fb_addr;
  assign fb.fb_rd_en  = r_rd_en;
  assign vblank_start = w_vblank;
  assign VGA_CLK      = w_pix_clk;
  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_BLANK    = r_blank;
  assign VGA_SYNC     = 1'b0;
  assign VGA_R        = r_r;
  assign VGA_G        = r_g;
  assign VGA_B        = r_b;

endmodule
